// File: rtl/uart_tx_core_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and
// helpers that size the baud divider and the tick counter.
package uart_tx_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned OVERSAMPLE = 16;

  // Clock cycles per 16x tick, truncated, never below one.
  function automatic int baud_div(input logic [31:0] baudrate, input logic [31:0] frequency);
    logic [31:0] div;
    div = frequency / (baudrate * OVERSAMPLE);
    return (div == 32'd0) ? 1 : int'(div);
  endfunction

  // The tick counter must reach both 15 and the last stop tick.
  function automatic int tick_cnt_w(input int stop_ticks);
    return $clog2((stop_ticks > 16) ? stop_ticks : 16);
  endfunction

endpackage

// File: rtl/tx_baudrate_tick_generator.sv
// 16x baud tick generator: one-cycle pulse every DIV clocks, restartable
// with clear so a frame's start bit always gets a full 16*DIV cycles.
module tx_baudrate_tick_generator
  import uart_tx_core_pkg::*;
#(
  parameter logic [31:0] BAUDRATE  = 32'd9600,
  parameter logic [31:0] FREQUENCY = 32'd100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int DIV   = baud_div(BAUDRATE, FREQUENCY);
  localparam int CNT_W = $clog2(DIV) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, data LSB first, stop ticks, timed from a
// 16x baud tick. All outputs are flops, so the TX pin never glitches.
module uart_tx_core
  import uart_tx_core_pkg::*;
#(
  parameter int          NUMBER_OF_DATA_BITS      = 8,
  parameter int          NUMBER_OF_STOP_BIT_TICKS = 16,
  parameter logic [31:0] BAUDRATE                 = 32'd9600,
  parameter logic [31:0] FREQUENCY                = 32'd100000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tx_start,
  input  logic [NUMBER_OF_DATA_BITS-1:0] data_in,
  output logic                           tx,
  output logic                           tx_busy,
  output logic                           tx_done_tick
);

  localparam int N      = NUMBER_OF_DATA_BITS;
  localparam int TICK_W = tick_cnt_w(NUMBER_OF_STOP_BIT_TICKS);
  localparam int BIT_W  = $clog2(N);
  localparam logic [TICK_W-1:0] OS_LAST   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(NUMBER_OF_STOP_BIT_TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N - 1);

  tx_state_t         state, state_next;
  logic [TICK_W-1:0] tick_cnt, tick_cnt_next;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_next;
  logic [N-1:0]      shift, shift_next;
  logic              tick, accept;
  logic              tx_next, busy_next, done_next;

  tx_baudrate_tick_generator #(
    .BAUDRATE  (BAUDRATE),
    .FREQUENCY (FREQUENCY)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      state        <= state_next;
      tick_cnt     <= tick_cnt_next;
      bit_cnt      <= bit_cnt_next;
      shift        <= shift_next;
      tx           <= tx_next;
      tx_busy      <= busy_next;
      tx_done_tick <= done_next;
    end
  end

  // A request arriving while tx_done_tick is high is ignored, so the earliest
  // new frame starts the cycle after the done pulse.
  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift;
    accept        = 1'b0;
    tx_next       = 1'b1;
    busy_next     = (state != ST_IDLE);
    done_next     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_start && !tx_done_tick) begin
          accept        = 1'b1;
          shift_next    = data_in;
          tick_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = ST_START;
        end
      end
      ST_START: begin
        tx_next = 1'b0;
        if (tick) begin
          if (tick_cnt == OS_LAST) begin
            tick_cnt_next = '0;
            state_next    = ST_DATA;
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
      end
      ST_DATA: begin
        tx_next = shift[0];
        if (tick) begin
          if (tick_cnt == OS_LAST) begin
            tick_cnt_next = '0;
            shift_next    = {1'b0, shift[N-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state_next = ST_STOP;
            end else begin
              bit_cnt_next = bit_cnt + BIT_W'(1);
            end
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tick_cnt == STOP_LAST) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core at DIV=4 (64 cycles per bit): frame shape, request
// handling, reset abort, two stop bits and a behavioural loopback decode.
module tb_uart_tx_core;

  localparam int BIT_CYC = 64;
  localparam int NBITS   = 8;
  localparam int FRAME1  = (16 * (1 + NBITS) + 16) * 4;
  localparam int FRAME2  = (16 * (1 + NBITS) + 32) * 4;
  localparam int NLOOP   = 96;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx, tx_busy, tx_done_tick;
  logic       tx_start_b = 1'b0;
  logic [7:0] data_in_b = 8'h00;
  logic       tx_b, tx_busy_b, tx_done_tick_b;

  int total = 0;
  int bad = 0;

  uart_tx_core #(
    .NUMBER_OF_DATA_BITS(8), .NUMBER_OF_STOP_BIT_TICKS(16),
    .BAUDRATE(32'd9600), .FREQUENCY(32'd614400)
  ) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .data_in(data_in),
    .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  uart_tx_core #(
    .NUMBER_OF_DATA_BITS(8), .NUMBER_OF_STOP_BIT_TICKS(32),
    .BAUDRATE(32'd9600), .FREQUENCY(32'd614400)
  ) dut_b (
    .clk(clk), .reset(reset), .tx_start(tx_start_b), .data_in(data_in_b),
    .tx(tx_b), .tx_busy(tx_busy_b), .tx_done_tick(tx_done_tick_b)
  );

  always #5 clk = ~clk;

  // Reference: a request is taken when no frame occupies the line, i.e. from
  // two edges after the previous frame's done edge; reset abandons any frame.
  int         cyc = 0;
  int         m_acc = -1000000;
  int         m_free = 0;
  logic [7:0] m_data = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_acc  <= -1000000;
      m_free <= 0;
    end else if (tx_start && cyc >= m_free) begin
      m_acc  <= cyc;
      m_data <= data_in;
      m_free <= cyc + FRAME1 + 2;
    end
  end

  // Line level c cycles after the accept edge: 64 cycles per bit.
  function automatic logic exp_tx(input int c, input logic [7:0] d, input int len);
    int b;
    if (c < 1 || c > len) return 1'b1;
    b = (c - 1) / BIT_CYC;
    if (b == 0) return 1'b0;
    if (b <= NBITS) return d[b-1];
    return 1'b1;
  endfunction

  function automatic int rel_cyc();
    return cyc - 1 - m_acc;
  endfunction

  task automatic test_reset();
    int   toggles;
    logic prev;
    reset = 1'b1;
    tx_start = 1'b0;
    repeat (5) @(negedge clk);
    total += 3;
    if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", tx_busy); end
    if (tx_done_tick !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", tx_done_tick); end
    reset = 1'b0;
    prev = tx;
    toggles = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== prev || tx !== 1'b1) toggles++;
      prev = tx;
    end
    total++;
    if (toggles !== 0) begin bad++; $display("FAIL idle_quiet toggles got=%0d want=0", toggles); end
  endtask

  task automatic test_frame_a5();
    int c, mism, first, done_at, done_cnt;
    mism = 0; first = -1; done_at = -1; done_cnt = 0;
    data_in = 8'hA5;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int i = 0; i <= FRAME1 + 4; i++) begin
      c = rel_cyc();
      if (tx !== exp_tx(c, m_data, FRAME1) || tx_busy !== (c >= 1 && c <= FRAME1) ||
          tx_done_tick !== (c == FRAME1)) begin
        if (first < 0) first = c;
        mism++;
      end
      if (tx_done_tick === 1'b1) begin done_cnt++; done_at = c; end
      @(negedge clk);
    end
    total += 3;
    if (mism !== 0) begin bad++; $display("FAIL a5_wave mismatches=%0d first_at=%0d want=0", mism, first); end
    if (done_at !== FRAME1) begin bad++; $display("FAIL a5_done_pos got=%0d want=%0d", done_at, FRAME1); end
    if (done_cnt !== 1) begin bad++; $display("FAIL a5_done_width got=%0d want=1", done_cnt); end
  endtask

  task automatic test_held_start();
    int c, mism, first, fall2;
    logic [7:0] d;
    mism = 0; first = -1; fall2 = -1;
    data_in = 8'hA5;
    tx_start = 1'b1;
    for (int i = 0; i <= 2 * (FRAME1 + 2) + 4; i++) begin
      @(negedge clk);
      c = rel_cyc();
      d = m_data;
      if (tx !== exp_tx(c, d, FRAME1) || tx_busy !== (c >= 1 && c <= FRAME1) ||
          tx_done_tick !== (c == FRAME1)) begin
        if (first < 0) first = i;
        mism++;
      end
      if (i > FRAME1 && fall2 < 0 && tx === 1'b0) fall2 = i;
      if (i == 300) data_in = 8'h3C;
      if (i == 700) tx_start = 1'b0;
    end
    total += 2;
    if (mism !== 0) begin bad++; $display("FAIL held_wave mismatches=%0d first_at=%0d want=0", mism, first); end
    if (fall2 !== FRAME1 + 3) begin bad++; $display("FAIL held_second_start got=%0d want=%0d", fall2, FRAME1 + 3); end
  endtask

  task automatic test_reset_mid();
    int c, mism, first, done_at;
    mism = 0; first = -1; done_at = -1;
    data_in = 8'h5A;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int i = 0; i < 1 + BIT_CYC * 4 + 20; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total += 2;
    if (tx !== 1'b1) begin bad++; $display("FAIL midreset_tx got=%b want=1", tx); end
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", tx_busy); end
    reset = 1'b0;
    data_in = 8'h00;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int i = 0; i <= FRAME1 + 4; i++) begin
      c = rel_cyc();
      if (tx !== exp_tx(c, 8'h00, FRAME1) || tx_busy !== (c >= 1 && c <= FRAME1) ||
          tx_done_tick !== (c == FRAME1)) begin
        if (first < 0) first = c;
        mism++;
      end
      if (tx_done_tick === 1'b1) done_at = c;
      @(negedge clk);
    end
    total += 2;
    if (mism !== 0) begin bad++; $display("FAIL after_reset_wave mismatches=%0d first_at=%0d want=0", mism, first); end
    if (done_at !== FRAME1) begin bad++; $display("FAIL after_reset_done got=%0d want=%0d", done_at, FRAME1); end
  endtask

  task automatic test_stop32();
    int mism, first, done_at, high;
    mism = 0; first = -1; done_at = -1; high = 0;
    data_in_b = 8'hFF;
    tx_start_b = 1'b1;
    @(negedge clk);
    tx_start_b = 1'b0;
    for (int c = 0; c <= FRAME2 + 4; c++) begin
      if (tx_b !== exp_tx(c, 8'hFF, FRAME2) || tx_busy_b !== (c >= 1 && c <= FRAME2) ||
          tx_done_tick_b !== (c == FRAME2)) begin
        if (first < 0) first = c;
        mism++;
      end
      if (tx_done_tick_b === 1'b1) done_at = c;
      if (c > 1 + BIT_CYC * (1 + NBITS) - 1 && c <= FRAME2 && tx_b === 1'b1) high++;
      @(negedge clk);
    end
    total += 3;
    if (mism !== 0) begin bad++; $display("FAIL stop32_wave mismatches=%0d first_at=%0d want=0", mism, first); end
    if (done_at !== FRAME2) begin bad++; $display("FAIL stop32_done got=%0d want=%0d", done_at, FRAME2); end
    if (high !== 128) begin bad++; $display("FAIL stop32_high got=%0d want=128", high); end
  endtask

  task automatic test_loopback();
    logic [7:0] sent[$];
    logic [8:0] rx_word;
    logic [8:0] want;
    int c, mism, first, n_acc, done_cnt, rx_cnt, t, i, limit;
    logic dec_on;
    mism = 0; first = -1; n_acc = 0; done_cnt = 0; rx_cnt = 0; t = 0; i = 0;
    dec_on = 1'b0; rx_word = '0;
    limit = NLOOP * (FRAME1 + 2) + 1000;
    data_in = 8'($urandom);
    tx_start = 1'b1;
    while (done_cnt < NLOOP && i < limit) begin
      @(negedge clk);
      i++;
      if (m_acc == cyc - 1) begin
        sent.push_back(data_in);
        n_acc++;
        if (n_acc == NLOOP) tx_start = 1'b0;
        else data_in = 8'($urandom);
      end
      c = rel_cyc();
      if (tx !== exp_tx(c, m_data, FRAME1) || tx_busy !== (c >= 1 && c <= FRAME1) ||
          tx_done_tick !== (c == FRAME1)) begin
        if (first < 0) first = i;
        mism++;
      end
      if (tx_done_tick === 1'b1) done_cnt++;
      // Mid-bit sampling, the way a 16x receiver would see the line.
      if (!dec_on) begin
        if (tx === 1'b0) begin dec_on = 1'b1; t = 0; end
      end else begin
        t++;
        if (t % BIT_CYC == BIT_CYC / 2) rx_word[t / BIT_CYC - 1] = tx;
        if (t == BIT_CYC * (1 + NBITS) + BIT_CYC / 2) begin
          dec_on = 1'b0;
          rx_cnt++;
          want = (sent.size() > 0) ? {1'b1, sent.pop_front()} : 9'h0xx;
          total++;
          if (rx_word !== want) begin
            bad++;
            $display("FAIL loop_byte%0d got stop/data=%h want=%h", rx_cnt, rx_word, want);
          end
        end
      end
    end
    tx_start = 1'b0;
    total += 3;
    if (rx_cnt !== NLOOP) begin bad++; $display("FAIL loop_rx_count got=%0d want=%0d", rx_cnt, NLOOP); end
    if (done_cnt !== rx_cnt) begin bad++; $display("FAIL loop_done_count got=%0d want=%0d", done_cnt, rx_cnt); end
    if (mism !== 0) begin bad++; $display("FAIL loop_wave mismatches=%0d first_at=%0d want=0", mism, first); end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    repeat (10) @(negedge clk);
    test_held_start();
    repeat (10) @(negedge clk);
    test_reset_mid();
    repeat (10) @(negedge clk);
    test_stop32();
    repeat (10) @(negedge clk);
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
